// File: rtl/midi_merge_pkg.sv
// midi_merge_pkg: arbiter states, MIDI byte constants and message classification helpers
package midi_merge_pkg;
    typedef enum logic [1:0] {IDLE, STATUS_INS, PASS, SYSEX} state_t;
    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END = 8'hF7;
    localparam logic [7:0] ACTIVE_SENSE = 8'hFE;
    function automatic logic is_realtime(input logic [7:0] b);
        return b >= 8'hF8;
    endfunction
    // 0 marks SysEx (variable length) or a non-status byte
    function automatic logic [1:0] msg_len(input logic [7:0] s);
        return (s[7:4] == 4'hC || s[7:4] == 4'hD || s == 8'hF1 || s == 8'hF3) ? 2'd2 :
               ((s[7] && s[7:4] != 4'hF) || s == 8'hF2) ? 2'd3 :
               (s == SYSEX_START || !s[7]) ? 2'd0 : 2'd1;
    endfunction
endpackage

// File: rtl/midi_byte_fifo.sv
// midi_byte_fifo: single-clock show-ahead byte FIFO; writes into a full FIFO are dropped unless a read frees a slot
module midi_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic       full,
    input  logic       rd,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_wr, do_rd;
    assign empty = wp == rp;
    assign full = wp == {~rp[AW], rp[AW-1:0]};
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);
    assign overflow = wr && !do_wr;
    assign rdata = mem[rp[AW-1:0]];
    always_ff @(posedge clk)
        if (do_wr) mem[wp[AW-1:0]] <= wdata;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (AW + 1)'(do_wr);
            rp <= rp + (AW + 1)'(do_rd);
        end
endmodule

// File: rtl/midi_stream_merger.sv
// midi_stream_merger: message-atomic round-robin MIDI merger with running-status expansion; MIDI_MERGE_ACTIVE_SENSE_FILTER_EN drops FE on input
module midi_stream_merger
    import midi_merge_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 fpga_clk,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    input  logic                 out_ready,
    output logic [NUM_SRC-1:0]   ovf_flag,
    input  logic                 ovf_clr,
    output logic                 busy
);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    logic [NUM_SRC-1:0] fifo_wr, fifo_rd, fifo_empty, fifo_ovf, rs_ok;
    logic [7:0] fifo_rdata [NUM_SRC];
    logic [7:0] rs [NUM_SRC];
    state_t state, nstate;
    logic [1:0] rem, nrem;
    logic [SW-1:0] rr, gnt, sel, idx, cur;
    logic any, pop, emit, grab, out_free;
    logic [7:0] head, obyte;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
`ifdef MIDI_MERGE_ACTIVE_SENSE_FILTER_EN
        assign fifo_wr[i] = src_valid[i] && src_data[8*i +: 8] != ACTIVE_SENSE;
`else
        assign fifo_wr[i] = src_valid[i];
`endif
        midi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk(fpga_clk),
            .rst(reset),
            .wr(fifo_wr[i]),
            .wdata(src_data[8*i +: 8]),
            .full(),
            .rd(fifo_rd[i]),
            .rdata(fifo_rdata[i]),
            .empty(fifo_empty[i]),
            .overflow(fifo_ovf[i])
        );
    end

    // Scan downwards so the source closest to rr wins
    always_comb begin
        sel = rr;
        idx = '0;
        any = 1'b0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = SW'((int'(rr) + k) % NUM_SRC);
            if (!fifo_empty[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end

    assign cur = (state == IDLE) ? sel : gnt;
    assign head = fifo_rdata[cur];
    assign out_free = !out_valid || out_ready;
    assign fifo_rd = {NUM_SRC{pop}} & (NUM_SRC'(1) << cur);
    assign busy = state != IDLE;

    always_comb begin
        nstate = state;
        nrem = rem;
        pop = 1'b0;
        emit = 1'b0;
        grab = 1'b0;
        obyte = head;
        if (out_free)
            case (state)
                IDLE: if (any) begin
                    grab = 1'b1;
                    if (is_realtime(head)) begin
                        emit = 1'b1;
                        pop = 1'b1;
                    end else if (!head[7]) begin
                        pop = !rs_ok[cur];
                        nstate = rs_ok[cur] ? STATUS_INS : IDLE;
                    end else if (head == SYSEX_START) begin
                        emit = 1'b1;
                        pop = 1'b1;
                        nstate = SYSEX;
                    end else if (head == 8'hF4 || head == 8'hF5 || head == SYSEX_END) begin
                        pop = 1'b1;
                    end else begin
                        emit = 1'b1;
                        pop = 1'b1;
                        nrem = msg_len(head) - 2'd1;
                        nstate = (msg_len(head) == 2'd1) ? IDLE : PASS;
                    end
                end
                STATUS_INS: begin
                    emit = 1'b1;
                    obyte = rs[gnt];
                    nrem = msg_len(rs[gnt]) - 2'd1;
                    nstate = PASS;
                end
                PASS: if (!fifo_empty[gnt]) begin
                    emit = !head[7] || is_realtime(head);
                    pop = emit;
                    nrem = head[7] ? rem : rem - 2'd1;
                    nstate = (!emit || (!head[7] && rem == 2'd1)) ? IDLE : PASS;
                end
                SYSEX: if (!fifo_empty[gnt]) begin
                    // A foreign status byte closes the dump with a synthetic F7 and is left for IDLE
                    emit = 1'b1;
                    pop = head == SYSEX_END || !head[7] || is_realtime(head);
                    obyte = pop ? head : SYSEX_END;
                    nstate = (pop && head != SYSEX_END) ? SYSEX : IDLE;
                end
                default: nstate = IDLE;
            endcase
    end

    always_ff @(posedge fpga_clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            rem <= '0;
            rr <= '0;
            gnt <= '0;
            rs_ok <= '0;
            ovf_flag <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            for (int k = 0; k < NUM_SRC; k++) rs[k] <= '0;
        end else begin
            state <= nstate;
            rem <= nrem;
            ovf_flag <= (ovf_flag & ~{NUM_SRC{ovf_clr}}) | fifo_ovf;
            if (grab) begin
                gnt <= sel;
                rr <= (int'(sel) == NUM_SRC - 1) ? '0 : sel + 1'b1;
            end
            if (pop && head[7] && head[7:4] != 4'hF) begin
                rs[cur] <= head;
                rs_ok[cur] <= 1'b1;
            end else if (pop && head[7:3] == 5'b11110) begin
                rs_ok[cur] <= 1'b0;
            end
            if (out_free) begin
                out_valid <= emit;
                if (emit) out_data <= obyte;
            end
        end
endmodule

// File: tb/tb_midi_stream_merger.sv
// tb_midi_stream_merger: directed vectors with hand-computed merged output streams
module tb_midi_stream_merger;
    logic fpga_clk = 1'b0;
    logic reset;
    logic [2:0] src_valid;
    logic [23:0] src_data;
    logic out_valid;
    logic [7:0] out_data;
    logic out_ready;
    logic [2:0] ovf_flag;
    logic ovf_clr;
    logic busy;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0;
    logic [7:0] stim[$];
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int got_cyc[$];

    midi_stream_merger #(.NUM_SRC(3), .FIFO_DEPTH(16)) dut (
        .fpga_clk(fpga_clk),
        .reset(reset),
        .src_valid(src_valid),
        .src_data(src_data),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .ovf_flag(ovf_flag),
        .ovf_clr(ovf_clr),
        .busy(busy)
    );

    always #5 fpga_clk = ~fpga_clk;
    always @(posedge fpga_clk) cyc <= cyc + 1;
    always @(negedge fpga_clk)
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            got_cyc.push_back(cyc);
        end

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [23:0] d);
        src_valid = v;
        src_data = d;
        @(posedge fpga_clk);
        #1;
        src_valid = '0;
        src_data = '0;
    endtask

    task automatic send(input int s, input logic [7:0] b);
        drive(3'(1 << s), 24'(b) << (8 * s));
    endtask

    task automatic send_stim(input int s);
        foreach (stim[i]) send(s, stim[i]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge fpga_clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int t_in);
        int n = 0;
        while (got.size() < exp_q.size() && n < 300) begin
            @(posedge fpga_clk);
            n++;
        end
        tick(10);
        check({tag, " len"}, got.size(), exp_q.size());
        foreach (exp_q[i]) check(tag, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        if (t_in >= 0) check({tag, " lat"}, (got_cyc.size() > 0) ? got_cyc[0] - t_in : -1, 2);
        check({tag, " idle"}, busy, 0);
        got.delete();
        got_cyc.delete();
    endtask

    initial begin
        reset = 1'b1;
        src_valid = '0;
        src_data = '0;
        out_ready = 1'b1;
        ovf_clr = 1'b0;
        tick(3);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst ovf", ovf_flag, 0);
        check("rst busy", busy, 0);
        reset = 1'b0;
        tick(2);

        t0 = cyc;
        stim = '{8'h90, 8'h3C, 8'h64};
        send_stim(0);
        exp_q = '{8'h90, 8'h3C, 8'h64};
        expect_out("note_on", t0);

        stim = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h50};
        send_stim(0);
        exp_q = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h50};
        expect_out("running", -1);

        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        drive(3'b011, 24'h00_B0_90);
        drive(3'b011, 24'h00_07_40);
        drive(3'b011, 24'h00_64_7F);
        exp_q = '{8'h90, 8'h40, 8'h7F, 8'hB0, 8'h07, 8'h64};
        expect_out("two_src", -1);

        stim = '{8'hF0, 8'h43, 8'h10, 8'h80, 8'h40, 8'h00};
        send_stim(1);
        exp_q = '{8'hF0, 8'h43, 8'h10, 8'hF7, 8'h80, 8'h40, 8'h00};
        expect_out("sysex_abort", -1);

        stim = '{8'h40, 8'hF4, 8'hC0, 8'h05};
        send_stim(2);
        exp_q = '{8'hC0, 8'h05};
        expect_out("drop", -1);

        send(0, 8'h90);
        send(2, 8'hF8);
        tick(4);
        check("mid busy", busy, 1);
        check("mid held", got.size(), 1);
        stim = '{8'h3C, 8'hF8, 8'h64};
        send_stim(0);
        exp_q = '{8'h90, 8'h3C, 8'hF8, 8'h64, 8'hF8};
        expect_out("realtime", -1);

        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) send(0, (i == 0) ? 8'hF0 : 8'(i));
        check("ovf set", ovf_flag, 3'b001);
        check("ovf hold valid", out_valid, 1);
        check("ovf hold data", out_data, 8'hF0);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf clr", ovf_flag, 0);
        out_ready = 1'b1;
        send(0, 8'hF7);
        exp_q = '{8'hF0};
        for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hF7);
        expect_out("overflow", -1);

        stim = '{8'hFE, 8'hFE, 8'h90, 8'h3C, 8'h64};
        send_stim(1);
`ifdef MIDI_MERGE_ACTIVE_SENSE_FILTER_EN
        exp_q = '{8'h90, 8'h3C, 8'h64};
`else
        exp_q = '{8'hFE, 8'hFE, 8'h90, 8'h3C, 8'h64};
`endif
        expect_out("active_sense", -1);

        send(1, 8'hF0);
        send(1, 8'h43);
        tick(3);
        reset = 1'b1;
        tick(2);
        check("mid rst busy", busy, 0);
        check("mid rst valid", out_valid, 0);
        reset = 1'b0;
        tick(10);
        check("mid rst len", got.size(), 2);
        check("mid rst last", (got.size() > 1) ? 32'(got[1]) : 32'hFFFF_FFFF, 8'h43);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/midi_stream_merger.md
Name: midi_stream_merger

Overview:
- Merges NUM_SRC independent MIDI byte streams into one byte stream for the synthesizer MIDI decoder. Typical sources: hardware UART receiver, SoC MIDI register port, USB MIDI bridge.
- Arbitration is message-atomic: bytes from different sources never interleave inside a channel or system message, with the realtime exception below.
- Running status is expanded per source, so every output channel message carries an explicit status byte.

Parameters:
- NUM_SRC, 3, number of input byte streams (1..8).
- FIFO_DEPTH, 16, bytes buffered per source; power of two, at least 4.

Ports:
- fpga_clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source byte strobe, one cycle per byte.
- src_data  in  8*NUM_SRC  per-source byte; source i occupies bits [8i+7:8i].
- out_valid  out  1  merged byte available.
- out_data  out  8  merged byte.
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready.
- ovf_flag  out  NUM_SRC  sticky per-source FIFO overflow.
- ovf_clr  in  1  clears all ovf_flag bits.
- busy  out  1  arbiter is locked to a source mid-message.

Behaviour:
- Reset: out_valid=0, out_data=8'h00, ovf_flag=0, busy=0. All FIFOs are emptied, every per-source running status is cleared to "none", and the round-robin pointer is set to 0.
- Input: src_valid[i] writes src_data[i] into FIFO i. If FIFO i is full, the byte is dropped and ovf_flag[i] is set. A write and a read on the same FIFO in the same cycle are both honoured, including when the FIFO is full.
- Output register: out_valid/out_data are registered. They hold stable while out_valid && !out_ready, and the next byte is loaded in the handshake cycle, allowing one byte per cycle.
- Latency: a byte written to an empty FIFO with the arbiter in IDLE and out_ready high appears on out_valid 2 cycles after its src_valid cycle.
- Message length by status byte:
  - 8x, 9x, Ax, Bx, Ex, F2: 3 bytes.
  - Cx, Dx, F1, F3: 2 bytes.
  - F6: 1 byte.
  - F0: until F7.
  - F4, F5, stray F7: 1 byte, dropped.
  - F8..FF: realtime, 1 byte.
- Running status per source: an 8x..Ex status is stored. F0..F7 clears the stored status. Realtime bytes leave it unchanged.
- FSM states: IDLE, STATUS_INS, PASS, SYSEX.
- IDLE:
  - Grant the next source round-robin, starting after the last grant, among non-empty FIFOs.
  - Head is realtime: emit it and stay in IDLE.
  - Head is 8x..Ex or F1..F3: emit it, load remaining = len-1, go to PASS. A message with len=1 returns to IDLE.
  - Head is F0: emit it and go to SYSEX.
  - Head is a data byte (<80) and running status is valid: emit nothing from the FIFO; go to STATUS_INS.
  - Head is a data byte and there is no running status: pop and discard it, stay in IDLE.
- STATUS_INS: emit the stored status without popping the FIFO, load remaining = len-1, go to PASS.
- PASS:
  - Pop from the granted FIFO only.
  - A data byte is emitted and remaining is decremented; at 0, go to IDLE.
  - A realtime byte is emitted and remaining is unchanged.
  - A status byte arriving early aborts the message: go to IDLE without popping; that byte is handled fresh.
  - An empty FIFO stalls the FSM; other sources wait.
- SYSEX:
  - Pass all bytes from the granted source.
  - F7 is emitted and the FSM goes to IDLE.
  - Any other status byte aborts the SysEx: emit a synthetic F7, go to IDLE, leave the status byte unpopped.
- busy=1 in STATUS_INS, PASS and SYSEX.
- ovf_clr and a new overflow in the same cycle: the overflow wins and the flag stays set.
- Reset asserted mid-message discards everything, with no synthetic F7.

Optional Feature:
- MIDI_MERGE_ACTIVE_SENSE_FILTER_EN.
- Defined: FE bytes are discarded on FIFO write, so they never occupy FIFO space or set ovf_flag.
- Undefined: FE is treated like any other realtime byte.

Decomposition:
- Package midi_merge_pkg holds:
  - state enum (IDLE, STATUS_INS, PASS, SYSEX);
  - byte constants SYSEX_START=F0, SYSEX_END=F7, ACTIVE_SENSE=FE;
  - function msg_len(status) returning 0..3, where 0 means SysEx/variable;
  - function is_realtime(byte).
- Sub-module midi_byte_fifo: synchronous single-clock FIFO with parameter DEPTH and ports wr, wdata, full, rd, rdata (show-ahead), empty, overflow. It is instantiated NUM_SRC times.

Test Plan:
- Src0 sends 90 3C 64 while the consumer is always ready -> out 90 3C 64 with the first byte 2 cycles after the input.
- Src0 sends 90 3C 64 3E 50 (running status) -> out 90 3C 64 90 3E 50.
- Src0 and src1 send 90 40 7F and B0 07 64 in the same cycles -> two complete messages, no interleave; src0 first after reset, then src1.
- Src1 sends F0 43 10 and then 80 40 00 before any F7 -> out F0 43 10 F7 80 40 00.
- Src0 is mid-message (90 sent, data pending) and src2 sends F8 -> F8 is emitted after src0's message completes. Src0 injects F8 between its data bytes -> out 90 3C F8 64.
- Write 20 bytes to src0 with out_ready=0 and FIFO_DEPTH=16 -> ovf_flag[0]=1 and the first 16 bytes are preserved. Pulse ovf_clr -> ovf_flag[0]=0.
- With MIDI_MERGE_ACTIVE_SENSE_FILTER_EN defined, send FE FE 90 3C 64 -> out 90 3C 64 only.
